multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26], sampled in DECODE.
REQ-005 funct  input  6  instruction bits [5:0], sampled in DECODE.
REQ-006 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  input  1  memory handshake; an access completes on a cycle with mem_ready=1.
REQ-008 ALUOp  output  2  00 R-type, 10 I-type/LW/SW, 01 branch; feeds ALUControl.
REQ-009 alu_funct  output  6  funct field driven to ALUControl.
REQ-010 IRWrite, PCWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg  output  1 each  datapath strobes.
REQ-011 retired  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 illegal  output  1  one-cycle pulse on an unknown opcode.
REQ-013 retire_count  output  16  count of retired instructions.

Function
REQ-014 Opcodes: R 000000, addi 100101, subi 100110, muli 101000, lw 100011, sw 101011, beq 000100; any other value is illegal.
REQ-015 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH.
REQ-016 FETCH: MemRead=1; on mem_ready=1 assert IRWrite and PCWrite, then go to DECODE; with mem_ready=0, hold in FETCH with no strobes.
REQ-017 DECODE: latch opcode/funct and branch on opcode class.
  - R -> EXEC_R; addi/subi/muli -> EXEC_I; lw/sw -> MEM_ADDR; beq -> BRANCH.
  - illegal -> FETCH with illegal=1.
REQ-018 EXEC_R: ALUOp=00, alu_funct=latched funct, ALUSrc=0; then WB_ALU.
REQ-019 EXEC_I: ALUOp=10, alu_funct=latched opcode, ALUSrc=1; then WB_ALU.
REQ-020 MEM_ADDR: ALUOp=10, alu_funct=000000, ALUSrc=1; then lw -> MEM_RD, sw -> MEM_WR.
REQ-021 MEM_RD: MemRead=1; wait for mem_ready, then go to WB_MEM.
REQ-022 MEM_WR: MemWrite=1; wait for mem_ready, then pulse retired and go to FETCH.
REQ-023 WB_ALU: RegWrite=1, MemtoReg=0, RegDst=1 for R-type else 0; pulse retired; then FETCH.
REQ-024 WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0; pulse retired; then FETCH.
REQ-025 BRANCH: ALUOp=01, alu_funct=000000, ALUSrc=0; PCWrite=zero; pulse retired; then FETCH.
REQ-026 Latency with mem_ready held at 1: R/I = 4 cycles, lw = 5, sw = 4, beq = 3, illegal = 2 with no retired pulse.
REQ-027 Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle, with strobes held and no state change.
REQ-028 Strobes not named for a state SHALL be 0 in that state; ALUOp=00 and alu_funct=000000 outside the EXEC, MEM_ADDR and BRANCH states.
REQ-029 retire_count SHALL increment by 1 on each retired pulse and wrap from 0xFFFF to 0x0000.
REQ-030 Latched opcode/funct SHALL NOT change outside DECODE.

Reset
REQ-031 While reset=1 at a clock edge, the next state SHALL be FETCH, with all strobes, retired and illegal at 0, retire_count at 0, and latched opcode/funct at 0.
REQ-032 Reset SHALL take priority over every transition, including mid-instruction and during a memory wait; no retired pulse is produced for the aborted instruction.
REQ-033 The first FETCH after reset is released SHALL assert MemRead in that same cycle.

Structure
REQ-034 Shared package ctrl_pkg SHALL hold the opcode constants, the ALUOp encodings (00/10/01) and the state enumeration.
REQ-035 The opcode classifier SHALL be a sub-module opcode_class (opcode -> is_r, is_i, is_lw, is_sw, is_beq, is_illegal); the FSM and counter SHALL live in multicycle_control.

Verification
REQ-036 R add (opcode 000000, funct 100000), mem_ready=1 -> ALUOp=00 and alu_funct=100000 in cycle 3; RegWrite=1, RegDst=1, retired=1 in cycle 4.
REQ-037 lw with mem_ready=0 for 2 cycles in MEM_RD -> completes in 7 cycles; MemRead held through the wait; WB_MEM has MemtoReg=1; retire_count +1.
REQ-038 beq with zero=1, then zero=0 -> PCWrite=1 then 0 in BRANCH; ALUOp=01 both times; 3 cycles each.
REQ-039 opcode 111111 -> illegal=1 in cycle 2, back to FETCH, retire_count unchanged, no RegWrite or MemWrite.
REQ-040 reset asserted during a MEM_WR stall -> MemWrite=0 next cycle, state FETCH, retire_count=0; retire_count preset to 0xFFFF plus one retire -> 0x0000.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALUOp encodings
// and the FSM state enumeration.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b100101;
  localparam logic [5:0] OP_SUBI = 6'b100110;
  localparam logic [5:0] OP_MULI = 6'b101000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  localparam logic [1:0] ALUOP_R  = 2'b00;
  localparam logic [1:0] ALUOP_I  = 2'b10;
  localparam logic [1:0] ALUOP_BR = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH
  } state_t;

endpackage

// File: rtl/opcode_class.sv
// Decodes a 6-bit opcode into one-hot instruction classes; anything not
// recognised is flagged illegal.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_r,
  output logic       is_i,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_illegal
);

  always_comb begin
    is_r       = 1'b0;
    is_i       = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_R:                      is_r       = 1'b1;
      OP_ADDI, OP_SUBI, OP_MULI: is_i       = 1'b1;
      OP_LW:                     is_lw      = 1'b1;
      OP_SW:                     is_sw      = 1'b1;
      OP_BEQ:                    is_beq     = 1'b1;
      default:                   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register, opcode/funct latches and
// retired-instruction counter; strobes are decoded from the current state.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic [5:0]  alu_funct,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        retired,
  output logic        illegal,
  output logic [15:0] retire_count
);

  state_t      r_state;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic        r_is_r;
  logic        r_is_lw;
  logic [15:0] r_retire_count;

  logic w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_illegal;

  opcode_class u_class (
    .opcode     (opcode),
    .is_r       (w_is_r),
    .is_i       (w_is_i),
    .is_lw      (w_is_lw),
    .is_sw      (w_is_sw),
    .is_beq     (w_is_beq),
    .is_illegal (w_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_opcode       <= 6'd0;
      r_funct        <= 6'd0;
      r_is_r         <= 1'b0;
      r_is_lw        <= 1'b0;
      r_retire_count <= 16'd0;
    end else begin
      if (retired)
        r_retire_count <= r_retire_count + 16'd1;
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          r_funct  <= funct;
          r_is_r   <= w_is_r;
          r_is_lw  <= w_is_lw;
          if (w_is_r)                 r_state <= S_EXEC_R;
          else if (w_is_i)            r_state <= S_EXEC_I;
          else if (w_is_lw || w_is_sw) r_state <= S_MEM_ADDR;
          else if (w_is_beq)          r_state <= S_BRANCH;
          else                        r_state <= S_FETCH;
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= r_is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is held so the reset cycle is quiet.
  always_comb begin
    ALUOp     = ALUOP_R;
    alu_funct = 6'd0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    retired   = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   illegal = w_is_illegal;
        S_EXEC_R: begin
          ALUOp     = ALUOP_R;
          alu_funct = r_funct;
        end
        S_EXEC_I: begin
          ALUOp     = ALUOP_I;
          alu_funct = r_opcode;
          ALUSrc    = 1'b1;
        end
        S_MEM_ADDR: begin
          ALUOp  = ALUOP_I;
          ALUSrc = 1'b1;
        end
        S_MEM_RD:   MemRead = 1'b1;
        S_MEM_WR: begin
          MemWrite = 1'b1;
          retired  = mem_ready;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = r_is_r;
          retired  = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retired  = 1'b1;
        end
        S_BRANCH: begin
          ALUOp   = ALUOP_BR;
          PCWrite = zero;
          retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; strobes are compared as one packed
// vector {IRWrite,PCWrite,MemRead,MemWrite,RegWrite,RegDst,ALUSrc,MemtoReg,retired,illegal}.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic [5:0]  alu_funct;
  logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg;
  logic        retired, illegal;
  logic [15:0] retire_count;
  logic [9:0]  strb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign strb = {IRWrite, PCWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg, retired, illegal};

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ALUOp        (ALUOp),
    .alu_funct    (alu_funct),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .RegDst       (RegDst),
    .ALUSrc       (ALUSrc),
    .MemtoReg     (MemtoReg),
    .retired      (retired),
    .illegal      (illegal),
    .retire_count (retire_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 (FETCH with mem_ready=1) and cycle 2 (DECODE) of any instruction.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input string name);
    opcode = op; funct = fn; mem_ready = 1'b1; #1;
    n_cmp++; if (strb !== 10'b1110000000) begin n_bad++; $display("FAIL %s_fetch: strb=%b expected %b", name, strb, 10'b1110000000); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (strb !== 10'b0) begin n_bad++; $display("FAIL reset_strb: strb=%b expected %b", strb, 10'b0); end
    n_cmp++; if (retire_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: count=%h expected %h", retire_count, 16'd0); end
    n_cmp++; if ({ALUOp, alu_funct} !== 8'd0) begin n_bad++; $display("FAIL reset_alu: alu=%b expected %b", {ALUOp, alu_funct}, 8'd0); end
    reset = 1'b0; mem_ready = 1'b0; #1;
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL reset_first_fetch: strb=%b expected %b", strb, 10'b0010000000); end
    tick();
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL fetch_stall: strb=%b expected %b", strb, 10'b0010000000); end
  endtask

  task automatic test_r_type();
    fetch_decode(6'b000000, 6'b100000, "r");
    n_cmp++; if (strb !== 10'b0 || ALUOp !== 2'b00) begin n_bad++; $display("FAIL r_decode: strb=%b alu=%b expected 0/00", strb, ALUOp); end
    tick();
    opcode = 6'b111111; funct = 6'b000111; #1;  // latched funct must not follow the inputs
    n_cmp++; if ({ALUOp, alu_funct} !== 8'b00_100000) begin n_bad++; $display("FAIL r_exec_alu: alu=%b expected %b", {ALUOp, alu_funct}, 8'b00_100000); end
    n_cmp++; if (strb !== 10'b0) begin n_bad++; $display("FAIL r_exec_strb: strb=%b expected %b", strb, 10'b0); end
    tick();
    n_cmp++; if (strb !== 10'b0000110010) begin n_bad++; $display("FAIL r_wb: strb=%b expected %b", strb, 10'b0000110010); end
    n_cmp++; if ({ALUOp, alu_funct} !== 8'd0) begin n_bad++; $display("FAIL r_wb_alu: alu=%b expected %b", {ALUOp, alu_funct}, 8'd0); end
    tick();
    n_cmp++; if (retire_count !== 16'd1) begin n_bad++; $display("FAIL r_count: count=%h expected %h", retire_count, 16'd1); end
  endtask

  task automatic test_i_type();
    fetch_decode(6'b100101, 6'b010101, "addi");
    tick();
    n_cmp++; if ({ALUOp, alu_funct} !== 8'b10_100101) begin n_bad++; $display("FAIL addi_exec_alu: alu=%b expected %b", {ALUOp, alu_funct}, 8'b10_100101); end
    n_cmp++; if (strb !== 10'b0000001000) begin n_bad++; $display("FAIL addi_exec_strb: strb=%b expected %b", strb, 10'b0000001000); end
    tick();
    n_cmp++; if (strb !== 10'b0000100010) begin n_bad++; $display("FAIL addi_wb: strb=%b expected %b", strb, 10'b0000100010); end
    tick();
    n_cmp++; if (retire_count !== 16'd2) begin n_bad++; $display("FAIL addi_count: count=%h expected %h", retire_count, 16'd2); end
  endtask

  task automatic test_lw_stall();
    fetch_decode(6'b100011, 6'b000000, "lw");
    tick();
    n_cmp++; if ({ALUOp, alu_funct} !== 8'b10_000000 || strb !== 10'b0000001000) begin n_bad++; $display("FAIL lw_addr: alu=%b strb=%b expected 10000000/0000001000", {ALUOp, alu_funct}, strb); end
    tick();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0; #1;
      n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL lw_rd_wait%0d: strb=%b expected %b", i, strb, 10'b0010000000); end
      tick();
    end
    mem_ready = 1'b1; #1;
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL lw_rd_done: strb=%b expected %b", strb, 10'b0010000000); end
    tick();
    n_cmp++; if (strb !== 10'b0000100110) begin n_bad++; $display("FAIL lw_wb: strb=%b expected %b", strb, 10'b0000100110); end
    tick();
    n_cmp++; if (retire_count !== 16'd3) begin n_bad++; $display("FAIL lw_count: count=%h expected %h", retire_count, 16'd3); end
  endtask

  task automatic test_sw();
    fetch_decode(6'b101011, 6'b000000, "sw");
    tick(); tick();
    n_cmp++; if (strb !== 10'b0001000010) begin n_bad++; $display("FAIL sw_wr: strb=%b expected %b", strb, 10'b0001000010); end
    tick();
    mem_ready = 1'b0; #1;
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL sw_next_fetch: strb=%b expected %b", strb, 10'b0010000000); end
    n_cmp++; if (retire_count !== 16'd4) begin n_bad++; $display("FAIL sw_count: count=%h expected %h", retire_count, 16'd4); end
  endtask

  task automatic test_beq();
    logic [1:0] zv;
    zv = 2'b10;
    for (int i = 0; i < 2; i++) begin
      fetch_decode(6'b000100, 6'b000000, "beq");
      zero = zv[1 - i]; tick();
      n_cmp++; if (ALUOp !== 2'b01 || alu_funct !== 6'd0) begin n_bad++; $display("FAIL beq_alu%0d: alu=%b expected %b", i, {ALUOp, alu_funct}, 8'b01_000000); end
      n_cmp++; if (strb !== (zv[1 - i] ? 10'b0100000010 : 10'b0000000010)) begin n_bad++; $display("FAIL beq_strb%0d: strb=%b zero=%b", i, strb, zero); end
      tick();
    end
    n_cmp++; if (retire_count !== 16'd6) begin n_bad++; $display("FAIL beq_count: count=%h expected %h", retire_count, 16'd6); end
  endtask

  task automatic test_illegal();
    fetch_decode(6'b111111, 6'b000000, "ill");
    n_cmp++; if (strb !== 10'b0000000001) begin n_bad++; $display("FAIL ill_pulse: strb=%b expected %b", strb, 10'b0000000001); end
    tick();
    mem_ready = 1'b0; #1;
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL ill_back_fetch: strb=%b expected %b", strb, 10'b0010000000); end
    n_cmp++; if (retire_count !== 16'd6) begin n_bad++; $display("FAIL ill_count: count=%h expected %h", retire_count, 16'd6); end
  endtask

  task automatic test_reset_mid();
    fetch_decode(6'b101011, 6'b000000, "rst_sw");
    tick(); tick();
    mem_ready = 1'b0; #1;
    n_cmp++; if (strb !== 10'b0001000000) begin n_bad++; $display("FAIL rst_sw_stall: strb=%b expected %b", strb, 10'b0001000000); end
    reset = 1'b1;
    tick();
    n_cmp++; if (strb !== 10'b0 || retire_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid: strb=%b count=%h expected 0/0", strb, retire_count); end
    reset = 1'b0; #1;
    n_cmp++; if (strb !== 10'b0010000000) begin n_bad++; $display("FAIL rst_mid_fetch: strb=%b expected %b", strb, 10'b0010000000); end
  endtask

  task automatic test_wrap();
    force dut.r_retire_count = 16'hFFFF;
    tick();
    release dut.r_retire_count;
    #1;
    n_cmp++; if (retire_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preset: count=%h expected %h", retire_count, 16'hFFFF); end
    zero = 1'b0;
    fetch_decode(6'b000100, 6'b000000, "wrap");
    tick(); tick();
    n_cmp++; if (retire_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: count=%h expected %h", retire_count, 16'h0000); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_lw_stall();
    test_sw();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
